// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package acc_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_AND  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_MUL  = 3'd7
    } acc_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } acc_state_e;

    // Bit positions inside the packed status-flag register.
    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;
    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/acc_mul_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Latency: start at edge k, final product presented during the cycle ending at edge k+WIDTH.
// Backpressure: none; start is ignored while busy, caller must not rely on queuing.
// Ports: clk/rst_n; start + multiplicand/multiplier launch a multiply;
//        busy = iterating; done = last iteration this cycle (combinational strobe);
//        product = 2*WIDTH-bit running product including this cycle's add.
module acc_mul_seq
    import acc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    acc_state_e           state;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   prod;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   prod_nxt;

    // Product after this cycle's conditional add; on the final iteration this
    // is the finished result, handed to the owner to register alongside flags.
    assign prod_nxt = prod + (mplier[0] ? mcand : '0);

    assign busy    = (state == MUL);
    assign done    = (state == MUL) && (count == CW'(1));
    assign product = prod_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, multiplicand};
                        mplier <= multiplier;
                        prod   <= '0;
                        count  <= CW'(WIDTH);
                        state  <= MUL;
                    end
                end
                MUL: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/acc_unit.sv
// Accumulator with built-in ALU (LOAD/ADD/SUB/AND/SHL/SHR) and iterative MUL, plus Z/N/C/V flags.
// Latency: single-cycle ops complete at the accepting edge; MUL completes WIDTH edges later.
// Backpressure: none; ops offered while busy are dropped, not queued.
// Ports: clk/rst_n; op_valid/op/operand from control; busy, done (1-cycle pulse after a result),
//        acc_out, flag_z/flag_n/flag_c/flag_v.
module acc_unit
    import acc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);

    acc_op_e                op_e;
    logic [WIDTH-1:0]       acc;
    logic [NUM_FLAGS-1:0]   flags;
    logic                   accept;
    logic                   mul_start;
    logic                   mul_busy;
    logic                   mul_done;
    logic [2*WIDTH-1:0]     mul_prod;

    logic [WIDTH:0]         sum_ext;
    logic [WIDTH-1:0]       diff;
    logic [WIDTH-1:0]       alu_res;
    logic                   alu_c;
    logic                   alu_v;

    assign op_e      = acc_op_e'(op);
    assign accept    = op_valid && !mul_busy;
    assign mul_start = accept && (op_e == OP_MUL);

    acc_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_start),
        .multiplicand (acc),
        .multiplier   (operand),
        .busy         (mul_busy),
        .done         (mul_done),
        .product      (mul_prod)
    );

    assign sum_ext = {1'b0, acc} + {1'b0, operand};
    assign diff    = acc - operand;

    // Single-cycle ALU. NOP and MUL pass acc through; neither uses this path
    // to write state.
    always_comb begin
        alu_res = acc;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_e)
            OP_LOAD: alu_res = operand;
            OP_ADD: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                // Same-sign inputs producing an opposite-sign result.
                alu_v   = (acc[WIDTH-1] == operand[WIDTH-1]) &&
                          (sum_ext[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_c   = (acc < operand);
                // Different-sign inputs where the result sign flips from acc.
                alu_v   = (acc[WIDTH-1] != operand[WIDTH-1]) &&
                          (diff[WIDTH-1] != acc[WIDTH-1]);
            end
            OP_AND:  alu_res = acc & operand;
            OP_SHL: begin
                alu_res = {acc[WIDTH-2:0], 1'b0};
                alu_c   = acc[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, acc[WIDTH-1:1]};
                alu_c   = acc[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            flags <= '0;
            done  <= 1'b0;
        end else if (mul_done) begin
            // accept is low here (busy), so this never collides with a new op.
            acc           <= mul_prod[WIDTH-1:0];
            flags[FLAG_Z] <= ~|mul_prod[WIDTH-1:0];
            flags[FLAG_N] <= mul_prod[WIDTH-1];
            flags[FLAG_C] <= |mul_prod[2*WIDTH-1:WIDTH];
            flags[FLAG_V] <= 1'b0;
            done          <= 1'b1;
        end else if (accept && (op_e != OP_MUL)) begin
            done <= 1'b1;
            if (op_e != OP_NOP) begin
                acc           <= alu_res;
                flags[FLAG_Z] <= ~|alu_res;
                flags[FLAG_N] <= alu_res[WIDTH-1];
                flags[FLAG_C] <= alu_c;
                flags[FLAG_V] <= alu_v;
            end
        end else begin
            done <= 1'b0;
        end
    end

    assign busy    = mul_busy;
    assign acc_out = acc;
    assign flag_z  = flags[FLAG_Z];
    assign flag_n  = flags[FLAG_N];
    assign flag_c  = flags[FLAG_C];
    assign flag_v  = flags[FLAG_V];

endmodule
